serial_bit_packer: RTL and testbench

Upstream stage of the ones-counter: collects a serial bit stream into DATA_WIDTH-bit words and presents each word with a valid/ready handshake to the parallel population-count stage. It also keeps a running count of the 1 bits in each word as they arrive. That count is delivered alongside the word so downstream logic can cross-check the combinational count. The block holds one completed word and applies backpressure to the serial source only when that word cannot be delivered.

---
 rtl/serial_bit_packer.sv | 84 ++++++++
 tb/tb_serial_bit_packer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_packer.sv
// serial_bit_packer: gathers an LSB-first serial bit stream into DATA_WIDTH-bit words and
// hands each word, with its ones count, to the popcount stage over a valid/ready handshake.
module serial_bit_packer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic [$clog2(DATA_WIDTH):0] dout_ones,
    output logic                        dout_valid,
    input  logic                        dout_ready
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    // Handshake: a transfer happens on a rising edge where valid && ready. dout_valid is
    // registered and never looks at dout_ready; din_ready may follow dout_ready in the same
    // cycle so a completing bit can land on the edge that consumes the held word.

    logic [DATA_WIDTH-2:0] r_shift;
    logic [IW-1:0]         r_idx;
    logic [CW-1:0]         r_ones;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [CW-1:0]         r_dout_ones;
    logic                  r_dout_valid;

    logic [DATA_WIDTH-2:0] w_shift_nxt;
    logic [CW-1:0]         w_din_ext;
    logic                  w_last;
    logic                  w_accept;

    assign w_last    = (r_idx == LAST_IDX);
    assign din_ready = resetn && (!w_last || !r_dout_valid || dout_ready);
    assign w_accept  = din_valid && din_ready;
    assign w_din_ext = {{(CW-1){1'b0}}, din};

    always_comb begin
        w_shift_nxt = r_shift;
        for (int i = 0; i < DATA_WIDTH - 1; i++) begin
            if (r_idx == IW'(i)) begin
                w_shift_nxt[i] = din;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shift      <= '0;
            r_idx        <= '0;
            r_ones       <= '0;
            r_dout       <= '0;
            r_dout_ones  <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_last) begin
                    r_dout      <= {din, r_shift};
                    r_dout_ones <= r_ones + w_din_ext;
                    r_idx       <= '0;
                    r_ones      <= '0;
                end else begin
                    r_shift <= w_shift_nxt;
                    r_ones  <= r_ones + w_din_ext;
                    r_idx   <= r_idx + IW'(1);
                end
            end
            // A completing bit wins over consumption so back-to-back words have no bubble.
            if (w_accept && w_last) begin
                r_dout_valid <= 1'b1;
            end else if (dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_ones  = r_dout_ones;
    assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_serial_bit_packer.sv
// Bench for serial_bit_packer: directed scenarios plus randomized traffic, with a
// scoreboard queue of expected {ones, word} pairs checked by an independent monitor.
module tb_serial_bit_packer;
    localparam int W  = 16;
    localparam int CW = $clog2(W) + 1;

    logic          clk       = 1'b0;
    logic          resetn    = 1'b0;
    logic          din       = 1'b0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [W-1:0]  dout;
    logic [CW-1:0] dout_ones;
    logic          dout_valid;
    logic          dout_ready;

    logic ready_cmd = 1'b0;
    logic rand_mode = 1'b0;
    logic rand_rdy  = 1'b0;
    assign dout_ready = rand_mode ? rand_rdy : ready_cmd;

    logic [CW+W-1:0] exp_q[$];
    int              del_cyc[$];
    int              cyc       = 0;
    int              n_checks  = 0;
    int              n_errors  = 0;
    logic            watch_b2b = 1'b0;
    int              b2b_vld   = 0;
    logic            prev_stall = 1'b0;

    serial_bit_packer #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_ones  (dout_ones),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rand_rdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an LSB-first packer reproduces the word as sent; ones = popcount.
    task automatic push_exp(input logic [W-1:0] w);
        exp_q.push_back({CW'($countones(w)), w});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic b);
        logic acc;
        int   n;
        n = 0;
        din_valid = 1'b1;
        din       = b;
        do begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 2000);
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    // mode 0: continuous, 1: idle cycle (din=1) after every bit, 2: random idle gaps
    task automatic send_bits(input logic [W-1:0] w, input int lo, input int hi, input int mode);
        for (int i = lo; i <= hi; i++) begin
            if (mode == 2 && $urandom_range(0, 3) == 0) begin
                din_valid = 1'b0;
                din       = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drive_bit(w[i]);
            if (mode == 1) begin
                din_valid = 1'b0;
                din       = 1'b1;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_left", 32'(exp_q.size()), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("valid_held", 32'(dout_valid), 32'd1);
                if (watch_b2b) begin
                    check("b2b_din_ready", 32'(din_ready), 32'd1);
                    if (dout_valid) b2b_vld++;
                end
                if (dout_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 32'(dout_valid), 32'd0);
                    end else begin
                        check("dout", 32'(dout), 32'(exp_q[0][W-1:0]));
                        check("dout_ones", 32'(dout_ones), 32'(exp_q[0][CW+W-1:W]));
                        if (dout_ready) begin
                            void'(exp_q.pop_front());
                            del_cyc.push_back(cyc);
                        end
                    end
                end
                prev_stall = dout_valid && !dout_ready;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] w;
        int           t0;

        // reset held with din_valid high
        resetn    = 1'b0;
        din_valid = 1'b1;
        din       = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ones", 32'(dout_ones), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd0);
        din_valid = 1'b0;
        resetn    = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_after_reset", 32'(din_ready), 32'd1);
        @(posedge clk);
        #1;

        // single word, one-cycle valid pulse
        ready_cmd = 1'b1;
        push_exp(16'hA5C3);
        send_bits(16'hA5C3, 0, 15, 0);
        din_valid = 1'b0;
        @(negedge clk);
        check("sw_valid_rise", 32'(dout_valid), 32'd1);
        @(negedge clk);
        check("sw_valid_pulse", 32'(dout_valid), 32'd0);
        wait_drain();

        // backpressure: completing bit of the second word stalls until consume
        ready_cmd = 1'b0;
        push_exp(16'hFFFF);
        push_exp(16'h0F0F);
        send_bits(16'hFFFF, 0, 15, 0);
        send_bits(16'h0F0F, 0, 14, 0);
        din_valid = 1'b1;
        din       = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_din_ready", 32'(din_ready), 32'd0);
            check("bp_dout", 32'(dout), 32'hFFFF);
            check("bp_ones", 32'(dout_ones), 32'd16);
            check("bp_valid", 32'(dout_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        ready_cmd = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(din_ready), 32'd1);
        @(posedge clk);
        #1;
        ready_cmd = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        check("bp_new_valid", 32'(dout_valid), 32'd1);
        check("bp_new_dout", 32'(dout), 32'h0F0F);
        check("bp_new_ones", 32'(dout_ones), 32'd8);
        @(posedge clk);
        #1;
        ready_cmd = 1'b1;
        wait_drain();

        // input gaps: bit k lands on edge 2k+1, so the word shows 31 edges after bit 0 is offered
        del_cyc.delete();
        push_exp(16'h0001);
        t0 = cyc;
        send_bits(16'h0001, 0, 15, 1);
        din_valid = 1'b0;
        wait_drain();
        check("gap_latency", (del_cyc.size() == 1) ? 32'(del_cyc[0] - t0) : 32'hFFFF_FFFF, 32'd31);

        // asynchronous reset in the middle of a word
        send_bits(16'h007F, 0, 6, 0);
        din_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("rmid_dout", 32'(dout), 32'd0);
        check("rmid_ones", 32'(dout_ones), 32'd0);
        check("rmid_valid", 32'(dout_valid), 32'd0);
        check("rmid_din_ready", 32'(din_ready), 32'd0);
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        push_exp(16'h8000);
        send_bits(16'h8000, 0, 15, 0);
        din_valid = 1'b0;
        wait_drain();

        // back-to-back words with no bubble
        del_cyc.delete();
        b2b_vld = 0;
        push_exp(16'h0000);
        push_exp(16'hFFFF);
        push_exp(16'h8001);
        watch_b2b = 1'b1;
        send_bits(16'h0000, 0, 15, 0);
        send_bits(16'hFFFF, 0, 15, 0);
        send_bits(16'h8001, 0, 15, 0);
        din_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        watch_b2b = 1'b0;
        wait_drain();
        check("b2b_words", 32'(del_cyc.size()), 32'd3);
        if (del_cyc.size() == 3) begin
            check("b2b_gap0", 32'(del_cyc[1] - del_cyc[0]), 32'd16);
            check("b2b_gap1", 32'(del_cyc[2] - del_cyc[1]), 32'd16);
        end
        check("b2b_valid_cycles", 32'(b2b_vld), 32'd3);

        // randomized words, gaps and downstream backpressure
        rand_mode = 1'b1;
        repeat (40) begin
            w = W'($urandom);
            push_exp(w);
            send_bits(w, 0, 15, 2);
        end
        din_valid = 1'b0;
        rand_mode = 1'b0;
        ready_cmd = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
